// File: rtl/spi_slave_rx.sv
// SPI receive stage: syncs sclk/cs/mosi, shifts words on sclk fall, queues them in a FWFT FIFO.
// Ports: clk, rst (async high); sclk, cs (active low), mosi from the master;
//        dout/dout_valid/dout_ready consumer side; frame_err, overflow pulses; fifo_count occupancy.
module spi_slave_rx #(
    parameter int bits       = 12,
    parameter int fifo_depth = 4,
    parameter bit lsb_first  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sclk,
    input  logic                        cs,
    input  logic                        mosi,
    output logic [bits-1:0]             dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(fifo_depth):0] fifo_count
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(bits + 1);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_RECV      = 2'd2;

    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic [1:0] prime_q;
    logic primed;
    logic sample;

    logic [1:0]      state, state_nx;
    logic [bits-1:0] sh_q, sh_nx, sh_in;
    logic [NW-1:0]   cnt_q, cnt_nx, cnt_inc, cnt_eff;
    logic            done;
    logic            push;
    logic            err_nx;

    logic [bits-1:0] mem [fifo_depth];
    logic [AW-1:0]   rd_ptr, wr_ptr, rd_inc;
    logic [CW-1:0]   count, count_nx;
    logic [bits-1:0] dout_q, dout_nx;
    logic            full, empty, pop, wr_en, ovf_nx;

    // Two-flop synchronisers; sclk_d is a third stage for fall detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            prime_q <= 2'b00;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            prime_q <= {prime_q[0], 1'b1};
        end
    end

    // cs_s2 holds its reset preset for two cycles after release; the
    // idle-wait must not trust it until real samples have propagated.
    assign primed = prime_q[1];
    assign sample = sclk_d & ~sclk_s2;

    assign sh_in = lsb_first ? {mosi_s2, sh_q[bits-1:1]}
                             : {sh_q[bits-2:0], mosi_s2};

    assign cnt_inc = cnt_q + NW'(1);
    assign done    = sample && (cnt_inc == NW'(bits));
    assign cnt_eff = sample ? cnt_inc : cnt_q;

    always_comb begin
        state_nx = state;
        sh_nx    = sh_q;
        cnt_nx   = cnt_q;
        push     = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            ST_WAIT_IDLE: begin
                cnt_nx = '0;
                if (primed && cs_s2) state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_nx = '0;
                sh_nx  = '0;
                if (!cs_s2) state_nx = ST_RECV;
            end
            ST_RECV: begin
                if (sample) begin
                    sh_nx  = sh_in;
                    cnt_nx = done ? '0 : cnt_inc;
                    push   = done;
                end
                // A last bit landing with cs rise still completes the word.
                if (cs_s2) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    err_nx   = !done && (cnt_eff != '0);
                end
            end
            default: state_nx = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_WAIT_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            sh_q      <= sh_nx;
            cnt_q     <= cnt_nx;
            frame_err <= err_nx;
        end
    end

    assign full   = (count == CW'(fifo_depth));
    assign empty  = (count == '0);
    assign pop    = !empty && dout_ready;
    assign wr_en  = push && (!full || pop);
    assign ovf_nx = push && full && !pop;
    assign rd_inc = rd_ptr + AW'(1);

    always_comb begin
        count_nx = count;
        unique case ({wr_en, pop})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase
    end

    // dout is registered so it keeps the last popped word while empty
    // instead of exposing a stale slot at the new read pointer.
    always_comb begin
        dout_nx = dout_q;
        if (pop) begin
            if (count > CW'(1))
                dout_nx = mem[rd_inc];
            else if (wr_en)
                dout_nx = sh_in;
        end else if (empty && wr_en) begin
            dout_nx = sh_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < fifo_depth; i++)
                mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            dout_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= sh_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_inc;
            count    <= count_nx;
            dout_q   <= dout_nx;
            overflow <= ovf_nx;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = !empty;
    assign fifo_count = count;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized bench for spi_slave_rx: LSB-first and MSB-first instances
// share the SPI bus and are checked against a bit-list reference model.
module tb_spi_slave_rx;

    localparam int BITS  = 12;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst, sclk, cs, mosi, dout_ready;
    logic [BITS-1:0] dout_a, dout_b;
    logic valid_a, valid_b, ferr_a, ferr_b, ovf_a, ovf_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    spi_slave_rx #(.bits(BITS), .fifo_depth(DEPTH), .lsb_first(1'b1)) u_a (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout_a), .dout_valid(valid_a), .dout_ready(dout_ready),
        .frame_err(ferr_a), .overflow(ovf_a), .fifo_count(cnt_a)
    );

    spi_slave_rx #(.bits(BITS), .fifo_depth(DEPTH), .lsb_first(1'b0)) u_b (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout_b), .dout_valid(valid_b), .dout_ready(dout_ready),
        .frame_err(ferr_b), .overflow(ovf_b), .fifo_count(cnt_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int errs_a = 0, errs_b = 0, ovfs_a = 0, ovfs_b = 0;
    int exp_errs = 0, exp_ovfs = 0;
    int m_occ = 0;

    logic [BITS-1:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    logic bitq[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_a && dout_ready) got_a.push_back(dout_a);
            if (valid_b && dout_ready) got_b.push_back(dout_b);
            if (ferr_a) errs_a++;
            if (ferr_b) errs_b++;
            if (ovf_a) ovfs_a++;
            if (ovf_b) ovfs_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic push_word(input logic [BITS-1:0] w);
        for (int i = 0; i < BITS; i++) bitq.push_back(w[i]);
    endtask

    // mode 0: plain; 1: check latency on last bit; 2: pulse ready in push cycle
    task automatic send_frame(input int h, input int mode);
        cs = 1'b0;
        ticks(4);
        for (int i = 0; i < bitq.size(); i++) begin
            sclk = 1'b1;
            mosi = bitq[i];
            ticks(h);
            sclk = 1'b0;
            if (i == bitq.size() - 1 && mode != 0) begin
                tick();
                tick();
                if (mode == 1) check("lat_k1", 32'(valid_a), 32'd0);
                else dout_ready = 1'b1;
                tick();
                if (mode == 1) begin
                    check("lat_k2_a", 32'(valid_a), 32'd1);
                    check("lat_k2_b", 32'(valid_b), 32'd1);
                end else begin
                    dout_ready = 1'b0;
                end
                ticks(h - 3);
            end else begin
                ticks(h);
            end
        end
        ticks(h);
        cs = 1'b1;
        ticks(8);
    endtask

    // Reference: every BITS received bits form a word; the first bit is
    // weight 1 for the LSB-first unit and weight 2^(BITS-1) for the other.
    task automatic model_frame(input logic ready, input int mode);
        int nw, rem;
        logic [BITS-1:0] va, vb;
        nw  = bitq.size() / BITS;
        rem = bitq.size() % BITS;
        for (int w = 0; w < nw; w++) begin
            va = '0;
            vb = '0;
            for (int i = 0; i < BITS; i++) begin
                va[i]          = bitq[w*BITS+i];
                vb[BITS-1-i]   = bitq[w*BITS+i];
            end
            if (ready || (mode == 2 && w == nw - 1)) begin
                exp_a.push_back(va);
                exp_b.push_back(vb);
            end else if (m_occ < DEPTH) begin
                exp_a.push_back(va);
                exp_b.push_back(vb);
                m_occ++;
            end else begin
                exp_ovfs++;
            end
        end
        if (rem != 0) exp_errs++;
    endtask

    task automatic post_checks(input string tag);
        check({tag, "_ferr_a"}, 32'(errs_a), 32'(exp_errs));
        check({tag, "_ferr_b"}, 32'(errs_b), 32'(exp_errs));
        check({tag, "_ovf_a"}, 32'(ovfs_a), 32'(exp_ovfs));
        check({tag, "_ovf_b"}, 32'(ovfs_b), 32'(exp_ovfs));
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'(m_occ));
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'(m_occ));
    endtask

    task automatic drain(input string tag);
        dout_ready = 1'b1;
        ticks(12);
        dout_ready = 1'b0;
        tick();
        check({tag, "_n_a"}, 32'(got_a.size()), 32'(exp_a.size()));
        check({tag, "_n_b"}, 32'(got_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
            check({tag, "_wa"}, 32'(got_a[i]), 32'(exp_a[i]));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            check({tag, "_wb"}, 32'(got_b[i]), 32'(exp_b[i]));
        got_a.delete();
        got_b.delete();
        exp_a.delete();
        exp_b.delete();
        m_occ = 0;
    endtask

    task automatic run(input string tag, input int h, input logic ready,
                       input int mode);
        dout_ready = ready;
        send_frame(h, mode);
        dout_ready = 1'b0;
        model_frame(ready, mode);
        bitq.delete();
        post_checks(tag);
    endtask

    initial begin
        rst = 1'b1;
        sclk = 1'b0;
        cs = 1'b1;
        mosi = 1'b0;
        dout_ready = 1'b0;
        ticks(3);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        rst = 1'b0;
        ticks(4);

        push_word(12'hA5C);
        run("t1", 11, 1'b0, 1);
        drain("t1");

        for (int w = 1; w <= 5; w++) push_word(12'(w));
        run("t2", 4, 1'b0, 0);
        drain("t2");

        for (int i = 0; i < 7; i++) bitq.push_back(1'($urandom_range(0, 1)));
        run("t3p", 5, 1'b0, 0);
        push_word(12'hFFF);
        run("t3", 5, 1'b0, 0);
        drain("t3");

        for (int w = 0; w < 4; w++) push_word(12'($urandom));
        run("t4f", 3, 1'b0, 0);
        push_word(12'($urandom));
        run("t4", 4, 1'b0, 2);
        drain("t4");

        cs = 1'b0;
        ticks(4);
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1;
            mosi = 1'($urandom_range(0, 1));
            ticks(4);
            sclk = 1'b0;
            ticks(4);
        end
        rst = 1'b1;
        ticks(2);
        check("t5_rst_dout", 32'(dout_a), 32'd0);
        check("t5_rst_valid", 32'(valid_b), 32'd0);
        rst = 1'b0;
        ticks(2);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            mosi = 1'($urandom_range(0, 1));
            ticks(4);
            sclk = 1'b0;
            ticks(4);
        end
        cs = 1'b1;
        ticks(8);
        post_checks("t5r");
        push_word(12'h3C3);
        run("t5", 4, 1'b0, 0);
        drain("t5");

        bitq.push_back(1'b1);
        for (int i = 0; i < 10; i++) bitq.push_back(1'b0);
        bitq.push_back(1'b1);
        run("t6", 3, 1'b0, 0);
        drain("t6");

        for (int it = 0; it < 8; it++) begin
            int nw, part, h;
            logic rdy;
            h    = $urandom_range(3, 8);
            nw   = $urandom_range(0, 6);
            part = $urandom_range(0, 1) ? $urandom_range(1, 11) : 0;
            if (nw == 0 && part == 0) nw = 1;
            rdy  = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) push_word(12'($urandom));
            for (int i = 0; i < part; i++)
                bitq.push_back(1'($urandom_range(0, 1)));
            run("rnd", h, rdy, 0);
            drain("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receive stage that sits directly downstream of the team's SPI master. It consumes sclk/cs/mosi and recovers words in the system clock domain. Recovered words go into a small first-word-fall-through FIFO with a valid/ready output, so a consumer that runs slower than SPI can drain them. Framing errors and FIFO overflows are flagged.

Parameters:
bits, 12, word width in bits (>= 2)
fifo_depth, 4, FIFO entries (power of 2, >= 2)
lsb_first, 1, 1 = first received bit lands in dout[0]; 0 = first bit lands in dout[bits-1]

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI serial clock, asynchronous to clk
cs  input  1  chip select, active low, asynchronous to clk
mosi  input  1  serial data, asynchronous to clk
dout  output  bits  head-of-FIFO word; valid only while dout_valid=1
dout_valid  output  1  FIFO non-empty
dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1 on a clk edge
frame_err  output  1  one-cycle pulse: cs deasserted with a partial word
overflow  output  1  one-cycle pulse: completed word dropped because FIFO full
fifo_count  output  $clog2(fifo_depth)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, synchronous release): dout_valid=0, frame_err=0, overflow=0, fifo_count=0, dout=0.
- Reset also empties the FIFO, clears the shift register and bit counter, presets the synchronisers to sclk=0/cs=1/mosi=0, and sends the FSM to WAIT_IDLE.
- Input sync: sclk, cs and mosi each pass through two flops (s1, s2). A third flop on sclk (sclk_d) supports edge detection. All three inputs have equal sync latency.
- Sample event: falling edge of synced sclk (sclk_s2=0 and sclk_d=1). mosi_s2 is sampled at that edge. The upstream master changes mosi on sclk rise, so sampling on the fall is mandatory.
- Input timing requirement: sclk high and low phases are each >= 3 clk periods. Behaviour is undefined otherwise.
- FSM states:
  WAIT_IDLE: ignore everything until cs_s2=1, then go to IDLE. This protects against reset release in mid-frame.
  IDLE: bit counter=0. When cs_s2=0, go to RECV.
  RECV: on each sample event, shift the bit in and increment the counter.
- Word completion in RECV: when the counter reaches bits, push the word into the FIFO, reset the counter to 0 and stay in RECV. Further bits in the same frame start a new word.
- Frame end in RECV: when cs_s2=1, go to IDLE. If 0 < counter < bits, pulse frame_err for 1 cycle and discard the partial word. If counter = 0, the frame ends cleanly with no flag.
- Simultaneous events: if the last-bit sample and cs_s2 rising occur in the same cycle, the word completes and no frame_err is raised.
- Shift order, lsb_first=1: shift right with the new bit entering at [bits-1], so the first bit ends in [0]. Shift order, lsb_first=0: shift left with the new bit entering at [0].
- Latency: let k be the clk edge at which the raw sclk fall is first captured in s1. The FIFO write happens at edge k+2, and dout_valid is 1 after edge k+2 when the FIFO was empty.
- FIFO: FWFT. dout = mem[rd_ptr]. dout_valid = (fifo_count != 0).
- Pop: occurs when dout_valid and dout_ready are both 1.
- Full FIFO with push and no pop: the word is dropped, overflow pulses for 1 cycle, and FIFO contents are unchanged.
- Full FIFO with push and pop in the same cycle: both occur, the word is accepted, fifo_count is unchanged and there is no overflow.
- Empty FIFO: dout_ready is ignored. Push on an empty FIFO: the word appears on dout in the next cycle.
- Pointers wrap modulo fifo_depth. fifo_count ranges over 0..fifo_depth.
- frame_err and overflow may pulse in the same cycle.
- dout holds its last value when the FIFO is empty. It does not return to 0 except on reset.

Test Plan:
1. Single word, lsb_first=1: cs low, send 12'hA5C LSB first, sclk period 22 clk, cs high -> one word with dout=12'hA5C; dout_valid 2 edges after the last sclk fall is captured; frame_err=0.
2. Back-to-back frame, dout_ready=0: one cs-low frame carrying 5 words 12'h001..12'h005, fifo_depth=4 -> fifo_count=4; overflow pulses once on word 5; draining yields 001,002,003,004 in order.
3. Partial word: cs low, 7 bits, cs high -> frame_err pulses exactly once; fifo_count stays 0. The next full frame sending 12'hFFF is received correctly.
4. Full plus simultaneous pop: FIFO holding 4 words, dout_ready=1 held in the push cycle -> no overflow; fifo_count stays 4; the new word comes out 4th.
5. Reset mid-frame: assert rst after 6 bits of a word with cs still low, release, then send 3 more bits before cs high -> no word, no frame_err (WAIT_IDLE). The next frame with 12'h3C3 is received as 12'h3C3.
6. lsb_first=0: send bit sequence 1,0,0,0,0,0,0,0,0,0,0,1 -> dout=12'h801.
